draw_arbiter: RTL

DRAW_ARBITER -- requirements
Module: draw_arbiter

---
 rtl/draw_pkg.sv | 33 +++
 rtl/rr_pick.sv | 28 ++
 rtl/draw_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/draw_pkg.sv
// draw_pkg: shared types and constants for the drawing-engine arbiter.
//   state_e      - arbiter FSM states (IDLE, RUN, RELEASE)
//   VGA_W/VGA_H  - screen size in pixels
//   X_W/Y_W      - coordinate widths
//   COLOUR_W     - pixel colour width
//   WDOG_LIMIT   - RUN-cycle count at which a silent engine is aborted
//   idx_onehot() - engine index to one-hot start/ack vector
package draw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  localparam int          VGA_W      = 160;
  localparam int          VGA_H      = 120;
  localparam int          X_W        = 8;
  localparam int          Y_W        = 7;
  localparam int          COLOUR_W   = 3;
  localparam logic [15:0] WDOG_LIMIT = 16'hFFFF;

  function automatic logic [1:0] idx_onehot(input logic idx);
    logic [1:0] vec;
    if (idx) begin
      vec = 2'b10;
    end else begin
      vec = 2'b01;
    end
    return vec;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational 2-way round-robin picker.
// Ports:
//   req         in  2  pending requests
//   ptr         in  1  engine that wins a tie
//   grant_valid out 1  at least one request pending
//   grant_idx   out 1  chosen engine (lone request wins, tie goes to ptr)
module rr_pick
  import draw_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       grant_valid,
  output logic       grant_idx
);

  // Pick the lone requester, or the pointer engine when both ask.
  always_comb begin
    grant_valid = |req;
    grant_idx   = 1'b0;
    case (req)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ptr;
      default: grant_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/draw_arbiter.sv
// draw_arbiter: grants one of two drawing engines access to the VGA adapter.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req[1:0]                   job request per engine (held until ack)
//   ack[1:0]                   one-cycle job-complete pulse
//   eng_start[1:0]             start to engine, held until eng_done
//   eng_done[1:0]              done from engine
//   eng{0,1}_x/_y/_colour/_plot  engine pixel stream
//   vga_x/_y/_colour/_plot     owner's pixel stream, one cycle later
//   busy                       FSM not idle
//   owner                      engine currently/last granted
//   err                        sticky watchdog abort
// Optional feature: define DRAW_ARB_WATCHDOG_EN to abort a job whose engine
// stays silent for WDOG_LIMIT RUN cycles; otherwise err is tied low.
module draw_arbiter
  import draw_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req,
  output logic [1:0]          ack,
  output logic [1:0]          eng_start,
  input  logic [1:0]          eng_done,
  input  logic [X_W-1:0]      eng0_x,
  input  logic [Y_W-1:0]      eng0_y,
  input  logic [COLOUR_W-1:0] eng0_colour,
  input  logic                eng0_plot,
  input  logic [X_W-1:0]      eng1_x,
  input  logic [Y_W-1:0]      eng1_y,
  input  logic [COLOUR_W-1:0] eng1_colour,
  input  logic                eng1_plot,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                busy,
  output logic                owner,
  output logic                err
);

  state_e              state_r, state_nxt_s;
  logic                owner_r, owner_nxt_s;
  logic                ptr_r, ptr_nxt_s;
  logic [1:0]          start_r, start_nxt_s;
  logic [1:0]          ack_r, ack_nxt_s;
  logic [X_W-1:0]      vga_x_r, vga_x_nxt_s;
  logic [Y_W-1:0]      vga_y_r, vga_y_nxt_s;
  logic [COLOUR_W-1:0] vga_colour_r, vga_colour_nxt_s;
  logic                vga_plot_r, vga_plot_nxt_s;
  logic                busy_r, busy_nxt_s;

  logic                grant_valid_s, grant_idx_s;
  logic [X_W-1:0]      own_x_s;
  logic [Y_W-1:0]      own_y_s;
  logic [COLOUR_W-1:0] own_colour_s;
  logic                own_plot_s;
  logic                own_done_s;
  logic                wdog_trip_s;

  rr_pick u_rr_pick (
    .req         (req),
    .ptr         (ptr_r),
    .grant_valid (grant_valid_s),
    .grant_idx   (grant_idx_s)
  );

  // Select the current owner's pixel stream and done; the other engine is never routed.
  always_comb begin
    if (owner_r) begin
      own_x_s      = eng1_x;
      own_y_s      = eng1_y;
      own_colour_s = eng1_colour;
      own_plot_s   = eng1_plot;
    end else begin
      own_x_s      = eng0_x;
      own_y_s      = eng0_y;
      own_colour_s = eng0_colour;
      own_plot_s   = eng0_plot;
    end
    own_done_s = eng_done[owner_r];
  end

`ifdef DRAW_ARB_WATCHDOG_EN
  logic [15:0] wdog_cnt_r;
  logic        err_r;

  assign wdog_trip_s = (wdog_cnt_r == WDOG_LIMIT);
  assign err         = err_r;

  // Count RUN cycles of the current job; latch err when the limit aborts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_r <= 16'd0;
      err_r      <= 1'b0;
    end else begin
      if (state_r == ST_RUN) begin
        wdog_cnt_r <= wdog_cnt_r + 16'd1;
      end else begin
        wdog_cnt_r <= 16'd0;
      end
      if ((state_r == ST_RUN) && !own_done_s && wdog_trip_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end
`else
  assign wdog_trip_s = 1'b0;
  assign err         = 1'b0;
`endif

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt_s      = state_r;
    owner_nxt_s      = owner_r;
    ptr_nxt_s        = ptr_r;
    start_nxt_s      = start_r;
    ack_nxt_s        = 2'b00;
    vga_x_nxt_s      = vga_x_r;
    vga_y_nxt_s      = vga_y_r;
    vga_colour_nxt_s = vga_colour_r;
    vga_plot_nxt_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (grant_valid_s) begin
          owner_nxt_s = grant_idx_s;
          start_nxt_s = idx_onehot(grant_idx_s);
          state_nxt_s = ST_RUN;
        end else begin
          start_nxt_s = 2'b00;
        end
      end
      ST_RUN: begin
        vga_x_nxt_s      = own_x_s;
        vga_y_nxt_s      = own_y_s;
        vga_colour_nxt_s = own_colour_s;
        if (own_done_s) begin
          // Plot is suppressed on the completing cycle so RELEASE shows vga_plot=0.
          start_nxt_s = 2'b00;
          ack_nxt_s   = idx_onehot(owner_r);
          ptr_nxt_s   = ~owner_r;
          state_nxt_s = ST_RELEASE;
        end else if (wdog_trip_s) begin
          start_nxt_s = 2'b00;
          ptr_nxt_s   = ~owner_r;
          state_nxt_s = ST_RELEASE;
        end else begin
          vga_plot_nxt_s = own_plot_s;
        end
      end
      ST_RELEASE: begin
        // Wait for the engine to drop done so a stale done never ends the next job.
        if (!own_done_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RELEASE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        start_nxt_s = 2'b00;
      end
    endcase
    busy_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      owner_r      <= 1'b0;
      ptr_r        <= 1'b0;
      start_r      <= 2'b00;
      ack_r        <= 2'b00;
      vga_x_r      <= {X_W{1'b0}};
      vga_y_r      <= {Y_W{1'b0}};
      vga_colour_r <= {COLOUR_W{1'b0}};
      vga_plot_r   <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      owner_r      <= owner_nxt_s;
      ptr_r        <= ptr_nxt_s;
      start_r      <= start_nxt_s;
      ack_r        <= ack_nxt_s;
      vga_x_r      <= vga_x_nxt_s;
      vga_y_r      <= vga_y_nxt_s;
      vga_colour_r <= vga_colour_nxt_s;
      vga_plot_r   <= vga_plot_nxt_s;
      busy_r       <= busy_nxt_s;
    end
  end

  assign ack        = ack_r;
  assign eng_start  = start_r;
  assign vga_x      = vga_x_r;
  assign vga_y      = vga_y_r;
  assign vga_colour = vga_colour_r;
  assign vga_plot   = vga_plot_r;
  assign busy       = busy_r;
  assign owner      = owner_r;

endmodule
